// File: rtl/booth_ctrl.sv
// Booth multiplier sequencer: drives INIT/ADD/SUB/SHIFT steps of an external datapath.
// Define BOOTH_CTRL_CYCLE_CNT_EN to add the 8-bit `cycles` latency counter port.
module booth_ctrl #(
  parameter int BIT_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] signal,
  output logic       ready,
  output logic [1:0] dp_state,
  output logic       dp_step,
  output logic       busy,
  output logic       done,
  output logic       err
`ifdef BOOTH_CTRL_CYCLE_CNT_EN
  ,
  output logic [7:0] cycles
`endif
);

  localparam int CW = $clog2(BIT_LEN + 2);
  localparam logic [CW-1:0] CNT_LEN = CW'(BIT_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_LEN + 1);

  localparam logic [1:0] OP_INIT  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_EVAL,
    S_ADD,
    S_SUB,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            qprev_q, qprev_d;
  logic            b0_q, b0_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      dps_q, dps_d;

  logic b0, fin;
  assign b0  = signal[1];
  assign fin = signal[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      qprev_q <= 1'b0;
      b0_q    <= 1'b0;
      cnt_q   <= '0;
      dps_q   <= OP_INIT;
    end else begin
      state_q <= state_d;
      qprev_q <= qprev_d;
      b0_q    <= b0_d;
      cnt_q   <= cnt_d;
      dps_q   <= dps_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    qprev_d  = qprev_q;
    b0_d     = b0_q;
    cnt_d    = cnt_q;
    dp_state = dps_q;
    dp_step  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        dp_state = OP_INIT;
        dp_step  = 1'b1;
        qprev_d  = 1'b0;
        cnt_d    = '0;
        state_d  = S_EVAL;
      end
      S_EVAL: begin
        b0_d = b0;
        // a missing fin still terminates once one extra shift is done
        if (fin || cnt_q == CNT_MAX) begin
          state_d = S_DONE;
        end else begin
          unique case ({b0, qprev_q})
            2'b10:   state_d = S_SUB;
            2'b01:   state_d = S_ADD;
            default: state_d = S_SHIFT;
          endcase
        end
      end
      S_ADD: begin
        dp_state = OP_ADD;
        dp_step  = 1'b1;
        state_d  = S_SHIFT;
      end
      S_SUB: begin
        dp_state = OP_SUB;
        dp_step  = 1'b1;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        dp_state = OP_SHIFT;
        dp_step  = 1'b1;
        qprev_d  = b0_q;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        state_d  = S_EVAL;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    dps_d = dp_state;
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = ~ready;
  assign done  = (state_q == S_DONE);
  assign err   = done && (cnt_q != CNT_LEN);

`ifdef BOOTH_CTRL_CYCLE_CNT_EN
  logic [7:0] cyc_q, cyc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= 8'd0;
    else        cyc_q <= cyc_d;
  end

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == S_INIT) begin
      cyc_d = 8'd1;
    end else if (busy && cyc_q != 8'hff) begin
      cyc_d = cyc_q + 8'd1;
    end
  end

  assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_booth_ctrl.sv
// Random and directed Booth runs against a spec-level model,
// with a small behavioural datapath attached to the controller.
module tb_booth_ctrl;

  localparam int B = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] signal;
  logic       ready;
  logic [1:0] dp_state;
  logic       dp_step;
  logic       busy;
  logic       done;
  logic       err;
`ifdef BOOTH_CTRL_CYCLE_CNT_EN
  logic [7:0] cycles;
`endif

  booth_ctrl #(.BIT_LEN(B)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .signal   (signal),
    .ready    (ready),
    .dp_state (dp_state),
    .dp_step  (dp_step),
    .busy     (busy),
    .done     (done),
    .err      (err)
`ifdef BOOTH_CTRL_CYCLE_CNT_EN
    ,
    .cycles   (cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // datapath: A is one bit wider so M=-8 cannot overflow
  logic [B:0]   A;
  logic [B-1:0] Q;
  logic [B:0]   M;
  logic [B-1:0] mq;
  int           shifts;
  int           fin_mode;
  logic [1:0]   ops_q[$];
  logic         fin_v;

  always_comb begin
    fin_v = 1'b0;
    case (fin_mode)
      0:       fin_v = (shifts == B);
      1:       fin_v = (shifts >= 2);
      default: fin_v = 1'b0;
    endcase
  end
  assign signal = {Q[0], fin_v};

  always @(posedge clk) begin
    if (rst_n && dp_step) begin
      ops_q.push_back(dp_state);
      case (dp_state)
        2'b00: begin
          A <= '0;
          Q <= mq;
          shifts <= 0;
        end
        2'b01: A <= A + M;
        2'b10: A <= A - M;
        default: begin
          {A, Q} <= {A[B], A, Q[B-1:1]};
          shifts <= shifts + 1;
        end
      endcase
    end
  end

  // fin_mode: 0 normal, 1 fin after 2 shifts, 2 fin never
  task automatic run_op(input logic [B-1:0] m,
                        input logic [B-1:0] mc,
                        input int mode,
                        input bit poke);
    logic [1:0] exp_ops[$];
    int ncyc, k, npairs, sm, smc, prod;
    int bi, pv;
    bit got;
    logic errv;
    logic [2*B-1:0] p_got;
    mq = m;
    M = {mc[B-1], mc};
    fin_mode = mode;
    ops_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ncyc = 1;
    got = 1'b0;
    errv = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        got = 1'b1;
        errv = err;
        break;
      end
      start = (poke && ncyc == 4);
      @(negedge clk);
      ncyc++;
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    // model: pair i is {m[i], m[i-1]} with m[-1]=0
    npairs = (mode == 1) ? 2 : B;
    k = 0;
    exp_ops.push_back(2'b00);
    for (int i = 0; i < npairs; i++) begin
      bi = (int'(m) >> i) & 1;
      pv = (i == 0) ? 0 : ((int'(m) >> (i - 1)) & 1);
      if (bi == 1 && pv == 0) begin
        exp_ops.push_back(2'b10);
        k++;
      end else if (bi == 0 && pv == 1) begin
        exp_ops.push_back(2'b01);
        k++;
      end
      exp_ops.push_back(2'b11);
    end
    if (mode == 2) begin
      chk("err_nofin", 32'(errv), 32'd1);
      chk("shifts_nofin", 32'(shifts), 32'(B + 1));
    end else begin
      chk("err", 32'(errv), (mode == 1) ? 32'd1 : 32'd0);
      chk("latency", 32'(ncyc), 32'(3 + 2 * npairs + k));
      chk("nops", 32'(ops_q.size()), 32'(exp_ops.size()));
      for (int i = 0; i < exp_ops.size(); i++) begin
        if (i < ops_q.size())
          chk("op", 32'(ops_q[i]), 32'(exp_ops[i]));
      end
    end
    if (mode == 0) begin
      sm = m[B-1] ? int'(m) - (1 << B) : int'(m);
      smc = mc[B-1] ? int'(mc) - (1 << B) : int'(mc);
      prod = sm * smc;
      p_got = {A[B-1:0], Q};
      chk("product", 32'(p_got), 32'(prod[2*B-1:0]));
    end
    @(negedge clk);
    chk("ready_after", 32'(ready), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
`ifdef BOOTH_CTRL_CYCLE_CNT_EN
    chk("cycles", 32'(cycles), 32'(ncyc));
`endif
    if (poke) begin
      repeat (2) @(negedge clk);
      chk("no_restart", 32'(busy), 32'd0);
`ifdef BOOTH_CTRL_CYCLE_CNT_EN
      chk("cycles_hold", 32'(cycles), 32'(ncyc));
`endif
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_step"}, 32'(dp_step), 32'd0);
    chk({tag, "_dps"}, 32'(dp_state), 32'd0);
  endtask

  initial begin
    bit hit;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    mq = '0;
    M = '0;
    A = '0;
    Q = '0;
    shifts = 0;
    fin_mode = 0;
    #12;
    chk_reset_outs("rst");
`ifdef BOOTH_CTRL_CYCLE_CNT_EN
    chk("rst_cycles", 32'(cycles), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold", 32'(ready), 32'd1);

    run_op(4'b0000, 4'd3, 0, 1'b0);
    run_op(4'b0101, 4'd3, 0, 1'b0);
    run_op(4'b1111, 4'd3, 0, 1'b0);
    run_op(4'b0110, 4'b1000, 0, 1'b0);
    run_op(4'b1010, 4'd5, 1, 1'b0);
    run_op(4'b0011, 4'd2, 2, 1'b0);
    run_op(4'b1001, 4'd7, 0, 1'b1);
    for (int i = 0; i < 24; i++) begin
      run_op(4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 0, 1'b0);
    end

    // m=0001 gives SUB then ADD; hit reset in the ADD cycle
    mq = 4'b0001;
    M = 5'd3;
    fin_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dp_step && dp_state == 2'b01) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("add_reached", 32'(hit), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("arst");
`ifdef BOOTH_CTRL_CYCLE_CNT_EN
    chk("arst_cycles", 32'(cycles), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    run_op(4'b0101, 4'd3, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/booth_ctrl.md
BOOTH_CTRL -- requirements
Module: booth_ctrl

Interface
REQ-001 SHALL have parameter BIT_LEN, default 4, meaning operand width of the attached Booth datapath and the expected number of shift steps.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a new multiply, sampled only when ready=1.
REQ-005 SHALL have port ready  output  1  high iff FSM in IDLE.
REQ-006 SHALL have port signal  input  2  datapath status {b0, fin}: multiplier LSB, count-exhausted flag.
REQ-007 SHALL have port dp_state  output  2  datapath op code: 00 INIT, 01 ADD, 10 SUB, 11 SHIFT.
REQ-008 SHALL have port dp_step  output  1  one-cycle strobe: dp_state is valid for execution this cycle.
REQ-009 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-010 SHALL have port done  output  1  one-cycle pulse in the DONE state.
REQ-011 SHALL have port err  output  1  sequence-error flag, valid only while done=1.

Function
REQ-012 SHALL implement FSM states IDLE, INIT, EVAL, ADD, SUB, SHIFT, DONE.
REQ-013 SHALL go IDLE->INIT when start=1; start SHALL be ignored in every other state.
REQ-014 INIT SHALL drive dp_state=00, dp_step=1, clear qprev and shift counter, then go to EVAL.
REQ-015 EVAL SHALL go to DONE if fin=1; otherwise decode {b0,qprev}: 10->SUB, 01->ADD, 00/11->SHIFT.
REQ-016 ADD SHALL drive dp_state=01 and SUB SHALL drive dp_state=10, each with dp_step=1 for one cycle, then go to SHIFT.
REQ-017 SHIFT SHALL drive dp_state=11 and dp_step=1, load qprev with the b0 sampled in the preceding EVAL, increment the shift counter (saturating at BIT_LEN+1), then go to EVAL.
REQ-018 In IDLE, EVAL and DONE, dp_step SHALL be 0 and dp_state SHALL hold its last driven value.
REQ-019 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE; ready SHALL rise the following cycle.
REQ-020 err SHALL be 1 in DONE iff the shift counter is not equal to BIT_LEN, covering both early and missing fin.
REQ-021 EVAL with fin=0 and shift counter already equal to BIT_LEN+1 SHALL go directly to DONE with err=1, so every operation terminates.
REQ-022 Cycles from first INIT cycle to DONE, inclusive, SHALL be 3 + 2*BIT_LEN + k, where k is the number of ADD/SUB visits.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, qprev=0, counter=0, dp_state=00, dp_step=0, busy=0, done=0, err=0 and ready=1, including mid-operation.
REQ-024 After rst_n rises, the first state change SHALL require start=1 on a clk edge.

Configuration
REQ-025 With macro BOOTH_CTRL_CYCLE_CNT_EN defined, port cycles (output, 8 bits) SHALL exist.
REQ-026 In that configuration, cycles SHALL count clocks from INIT to DONE inclusive, saturating at 255, and SHALL hold from DONE until the next INIT; reset value 0.
REQ-027 Without BOOTH_CTRL_CYCLE_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 BIT_LEN=4, multiplier 0000, datapath model attached -> 4 SHIFT, k=0, done in cycle 11, err=0.
REQ-029 Multiplier 0101 -> op order SUB,SHIFT,ADD,SHIFT,SUB,SHIFT,ADD,SHIFT; k=4; done in cycle 15; product 3*5=15 when multiplicand is 3.
REQ-030 Multiplier 1111, multiplicand 3 -> SUB once, then SHIFT only; done in cycle 12; product -3.
REQ-031 fin forced to 1 after 2 shifts -> DONE with err=1; fin held at 0 -> done after BIT_LEN+1 shifts with err=1.
REQ-032 start pulsed while busy -> no restart; rst_n low during ADD -> IDLE with all outputs at reset values asynchronously.
REQ-033 With BOOTH_CTRL_CYCLE_CNT_EN, the scenario of REQ-029 -> cycles=15, held until the next start.
